// File: rtl/simon_decrypt.sv
// Iterative Simon 32/64 decryption core: one Feistel round per clock, round keys
// applied from key ROUNDS-1 down to key 0, plaintext returned over valid/ready.
module simon_decrypt #(
    parameter int WORD   = 16,
    parameter int ROUNDS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [32*WORD-1:0] key_total,
    input  logic               key_valid,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WORD-1:0]  ct_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WORD-1:0]  pt_out,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    state_t                      state_q, state_d;
    logic [WORD-1:0]             x_q, x_d, y_q, y_d;
    logic [4:0]                  idx_q, idx_d;
    logic                        ov_q, ov_d;
    logic [31:0][WORD-1:0]       keys;

    for (genvar i = 0; i < 32; i++) begin : g_keys
        assign keys[i] = key_total[WORD*i +: WORD];
    end

    function automatic logic [WORD-1:0] rotl(input logic [WORD-1:0] v, input int s);
        return (v << s) | (v >> (WORD - s));
    endfunction

    function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    // rst term keeps in_ready low for the whole reset window, not just after it
    assign in_ready  = rst && (state_q == IDLE) && key_valid;
    assign busy      = (state_q == RUN);
    assign out_valid = ov_q;
    assign pt_out    = {x_q, y_q};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_d     = ct_in[2*WORD-1:WORD];
                    y_d     = ct_in[WORD-1:0];
                    idx_d   = LAST;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = y_q;
                y_d = x_q ^ simon_f(y_q) ^ keys[idx_q];
                if (idx_q == 5'd0) begin
                    state_d = DONE;
                    ov_d    = 1'b1;
                end else begin
                    idx_d = idx_q - 5'd1;
                end
            end
            DONE: begin
                if (ov_q && out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_simon_decrypt.sv
// Directed bench for simon_decrypt: full 32-round vector, backpressure, busy and
// key gating, mid-run reset, and a single-round instance with zero keys.
module tb_simon_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] key_total;
    logic         key_valid, in_valid, out_ready;
    logic [31:0]  ct_in;
    logic         in_ready, out_valid, busy;
    logic [31:0]  pt_out;

    logic [511:0] key1;
    logic         kv1, iv1, or1;
    logic [31:0]  ct1;
    logic         ir1, ov1, busy1;
    logic [31:0]  pt1;

    int vectors = 0;
    int errors  = 0;

    localparam logic [31:0] CT = 32'hc69be9bb;
    localparam logic [31:0] PT = 32'h65656877;

    always #5 clk = ~clk;

    simon_decrypt #(.WORD(16), .ROUNDS(32)) dut (
        .clk(clk), .rst(rst), .key_total(key_total), .key_valid(key_valid),
        .in_valid(in_valid), .in_ready(in_ready), .ct_in(ct_in),
        .out_valid(out_valid), .out_ready(out_ready), .pt_out(pt_out), .busy(busy)
    );

    simon_decrypt #(.WORD(16), .ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .key_total(key1), .key_valid(kv1),
        .in_valid(iv1), .in_ready(ir1), .ct_in(ct1),
        .out_valid(ov1), .out_ready(or1), .pt_out(pt1), .busy(busy1)
    );

    function automatic logic [15:0] rotr16(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    // Reference Simon 32/64 key schedule (m=4, z0 sequence)
    function automatic logic [511:0] expand(input logic [63:0] key);
        logic [0:61]  z0;
        logic [15:0]  k [0:31];
        logic [15:0]  tmp;
        logic [511:0] bus;
        z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp  = rotr16(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ rotr16(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ {15'b0, z0[i-4]} ^ 16'h0003;
        end
        for (int i = 0; i < 32; i++) bus[16*i +: 16] = k[i];
        return bus;
    endfunction

    task automatic accept(input logic [31:0] ct);
        ct_in    = ct;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; key_valid = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ct_in = '0; key_total = expand(64'h1918_1110_0908_0100);
        kv1 = 1'b1; iv1 = 1'b0; or1 = 1'b0; ct1 = '0; key1 = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, busy, in_ready, pt_out} !== 35'd0) begin
            errors++;
            $display("FAIL reset: ov=%b busy=%b ir=%b pt=%h, want all zero",
                     out_valid, busy, in_ready, pt_out);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_standard;
        int cyc;
        @(posedge clk); #1;
        accept(CT);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL std_busy: busy=%b ir=%b want 1/0", busy, in_ready);
        end
        wait_done(cyc);
        vectors++;
        if (cyc != 32) begin
            errors++;
            $display("FAIL std_latency: got %0d want 32", cyc);
        end
        vectors++;
        if (pt_out !== PT) begin
            errors++;
            $display("FAIL std_pt: got %h want %h", pt_out, PT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL std_drain: ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        accept(CT);
        wait_done(cyc);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (pt_out !== PT || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: pt=%h ov=%b ir=%b want %h/1/0",
                         i, pt_out, out_valid, in_ready, PT);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy_reject;
        int cyc;
        int extra;
        accept(CT);
        repeat (4) @(posedge clk);
        #1;
        ct_in = 32'h12345678; in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: got %b want 0", in_ready);
        end
        in_valid = 1'b0;
        wait_done(cyc);
        vectors++;
        if (cyc != 22 || pt_out !== PT) begin
            errors++;
            $display("FAIL busy_result: cyc=%0d pt=%h want 22 (32 from accept) / %h",
                     cyc, pt_out, PT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) extra++;
        end
        vectors++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_no_second: %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_key_gating;
        int cyc;
        int bad;
        key_valid = 1'b0; ct_in = CT; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (in_ready || busy) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL keygate_hold: %0d cycles ready/busy want 0", bad);
        end
        key_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL keygate_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL keygate_accept: busy=%b want 1", busy);
        end
        wait_done(cyc);
        vectors++;
        if (cyc != 32 || pt_out !== PT) begin
            errors++;
            $display("FAIL keygate_result: cyc=%0d pt=%h want 32/%h", cyc, pt_out, PT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun;
        int cyc;
        accept(CT);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: ov=%b busy=%b ir=%b want 0/0/0",
                     out_valid, busy, in_ready);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        accept(CT);
        wait_done(cyc);
        vectors++;
        if (cyc != 32 || pt_out !== PT) begin
            errors++;
            $display("FAIL midrun_rerun: cyc=%0d pt=%h want 32/%h", cyc, pt_out, PT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_rounds1;
        ct1 = 32'h00010000; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        vectors++;
        if (ov1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL r1_run: ov=%b busy=%b want 0/1", ov1, busy1);
        end
        @(posedge clk); #1;
        vectors++;
        if (ov1 !== 1'b1 || pt1 !== 32'h00000001) begin
            errors++;
            $display("FAIL r1_result: ov=%b pt=%h want 1/00000001", ov1, pt1);
        end
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        vectors++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
            errors++;
            $display("FAIL r1_drain: ov=%b ir=%b want 0/1", ov1, ir1);
        end
    endtask

    initial begin
        test_reset;
        test_standard;
        test_backpressure;
        test_busy_reject;
        test_key_gating;
        test_reset_midrun;
        test_rounds1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
